// File: rtl/pulse_freq_meter_pkg.sv
// Shared definitions for the flood-control measurement and divider blocks:
// the meter state encoding, the system clock rate, and a counter width helper.
package pkg_flood_common;

   // System clock rate of the product, in Hz.
   localparam int unsigned SYS_CLK_HZ = 1000;

   // Meter control states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2
   } meter_state_e;

   // Bits needed to hold the values 0..n-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n < 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/pulse_freq_meter_sync_edge_det.sv
// Brings an asynchronous sensor line into the clk domain through a
// STAGES-deep flip-flop chain and flags each synchronized rising edge.
// rise is high for one cycle while the newest synchronized sample is 1
// and the previous one was 0.
module sync_edge_det #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync_reg;
   logic              sync_d_reg;

   // Shift the raw input through the synchronizer chain and keep one
   // delayed copy of the synchronized level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg   <= '0;
         sync_d_reg <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[STAGES-2:0], din};
         sync_d_reg <= sync_reg[STAGES-1];
      end
   end

   assign rise = sync_reg[STAGES-1] & ~sync_d_reg;

endmodule

// File: rtl/pulse_freq_meter.sv
// Pulse-rate meter: counts synchronized rising edges of pulse_in over a
// gate window of GATE_CYCLES clocks and publishes the count once per window.
// Windows run back to back while enable is high; a short settle period after
// enabling lets the synchronizer flush so an old level is never counted.
module pulse_freq_meter
   import pkg_flood_common::*;
#(
   parameter int unsigned GATE_CYCLES = 1000,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             enable,
   output logic [CNT_W-1:0] freq_out,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned GATE_W   = cnt_width(GATE_CYCLES);
   localparam int unsigned SETTLE_W = cnt_width(SYNC_STAGES + 1);

   localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0]   GATE_ONE    = GATE_W'(1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SYNC_STAGES);
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
   localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
   localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

   meter_state_e          state_reg;
   meter_state_e          state_next;
   logic [SETTLE_W-1:0]   settle_cnt_reg;
   logic [GATE_W-1:0]     gate_cnt_reg;
   logic [CNT_W-1:0]      edge_cnt_reg;
   logic                  ovf_pend_reg;
   logic [CNT_W-1:0]      freq_out_reg;
   logic                  freq_valid_reg;
   logic                  overflow_reg;

   logic                  rise;
   logic                  rise_meas;
   logic                  win_close;
   logic                  sat_now;
   logic [CNT_W-1:0]      edge_sum;

   sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_sync_edge_det (
      .clk  (clk),
      .rst  (rst),
      .din  (pulse_in),
      .rise (rise)
   );

   // Edges only count while measuring; during settle they may come from a
   // level that was already present before enabling.
   assign rise_meas = rise & (state_reg == MEASURE);
   assign win_close = (state_reg == MEASURE) && (gate_cnt_reg == GATE_LAST);

   // A rise arriving with the counter already full is lost: that is overflow.
   assign sat_now  = rise_meas & (edge_cnt_reg == CNT_MAX);
   assign edge_sum = (rise_meas && (edge_cnt_reg != CNT_MAX)) ?
                     (edge_cnt_reg + CNT_ONE) : edge_cnt_reg;

   // Next-state decision. The closing cycle always completes so the window
   // can publish; a low enable then drops the meter to IDLE one cycle later.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (!enable) begin
               state_next = IDLE;
            end else if (settle_cnt_reg == SETTLE_LAST) begin
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (!enable && !win_close) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Settle timer: counts the SYNC_STAGES+1 cycles spent in SETTLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt_reg <= '0;
      end else if ((state_reg == SETTLE) && (state_next == SETTLE)) begin
         settle_cnt_reg <= settle_cnt_reg + SETTLE_ONE;
      end else begin
         settle_cnt_reg <= '0;
      end
   end

   // Gate and edge counters. They restart on window close in the same cycle,
   // so a rise on the closing cycle lands in the closing window and a rise on
   // the next cycle lands in the new one. Leaving MEASURE clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         ovf_pend_reg <= 1'b0;
      end else if ((state_reg != MEASURE) || (state_next != MEASURE) || win_close) begin
         gate_cnt_reg <= '0;
         edge_cnt_reg <= '0;
         ovf_pend_reg <= 1'b0;
      end else begin
         gate_cnt_reg <= gate_cnt_reg + GATE_ONE;
         edge_cnt_reg <= edge_sum;
         ovf_pend_reg <= ovf_pend_reg | sat_now;
      end
   end

   // Publish the finished window; results hold until the next full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freq_out_reg   <= '0;
         overflow_reg   <= 1'b0;
         freq_valid_reg <= 1'b0;
      end else begin
         freq_valid_reg <= win_close;
         if (win_close) begin
            freq_out_reg <= edge_sum;
            overflow_reg <= ovf_pend_reg | sat_now;
         end
      end
   end

   assign freq_out   = freq_out_reg;
   assign freq_valid = freq_valid_reg;
   assign overflow   = overflow_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Bench for pulse_freq_meter. Two instances share all stimulus: an 8-bit
// counter and a 4-bit counter, both with a 100-cycle gate and 2 sync stages.
// Expected window results are queued when stimulus is issued and checked by
// a monitor that pops one entry per freq_valid, including the exact cycle.
// The cycle reference for a window is the first clock edge that samples
// enable high (E0); the first result appears after edge E0+103.
module tb_pulse_freq_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       pulse_in;
   logic       enable;

   logic [7:0] freq8;
   logic       v8, ovf8, busy8;
   logic [3:0] freq4;
   logic       v4, ovf4, busy4;

   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned passed = 0;
   int unsigned win_id = 0;
   int unsigned c0;

   typedef struct {
      int unsigned cyc;
      int unsigned id;
      logic [7:0]  f8;
      logic        o8;
      logic [3:0]  f4;
      logic        o4;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   pulse_freq_meter #(
      .GATE_CYCLES (100),
      .CNT_W       (8),
      .SYNC_STAGES (2)
   ) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .enable     (enable),
      .freq_out   (freq8),
      .freq_valid (v8),
      .overflow   (ovf8),
      .busy       (busy8)
   );

   pulse_freq_meter #(
      .GATE_CYCLES (100),
      .CNT_W       (4),
      .SYNC_STAGES (2)
   ) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .enable     (enable),
      .freq_out   (freq4),
      .freq_valid (v4),
      .overflow   (ovf4),
      .busy       (busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a square wave of the given period (high for the first half) for n cycles.
   task automatic run(input int unsigned period, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         pulse_in = ((i % period) < (period / 2));
         step();
      end
   endtask

   task automatic expect_win(input int unsigned at, input int unsigned f8, input bit o8,
                             input int unsigned f4, input bit o4);
      exp_t e;
      e.cyc = at;
      e.id  = win_id;
      e.f8  = 8'(f8);
      e.o8  = o8;
      e.f4  = 4'(f4);
      e.o4  = o4;
      sb.push_back(e);
      win_id++;
   endtask

   // Monitor: every freq_valid pops one expected window and compares it.
   always @(negedge clk) begin
      if ((v8 === 1'b1) || (v4 === 1'b1)) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'({v8, v4}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("window %0d at cycle %0d: freq8=%0d ovf8=%0d freq4=%0d ovf4=%0d",
                     mon_e.id, cyc, freq8, ovf8, freq4, ovf4);
            chk($sformatf("win%0d_cycle", mon_e.id), 32'(cyc), 32'(mon_e.cyc));
            chk($sformatf("win%0d_valid8", mon_e.id), 32'(v8), 32'd1);
            chk($sformatf("win%0d_valid4", mon_e.id), 32'(v4), 32'd1);
            chk($sformatf("win%0d_freq8", mon_e.id), 32'(freq8), 32'(mon_e.f8));
            chk($sformatf("win%0d_ovf8", mon_e.id), 32'(ovf8), 32'(mon_e.o8));
            chk($sformatf("win%0d_freq4", mon_e.id), 32'(freq4), 32'(mon_e.f4));
            chk($sformatf("win%0d_ovf4", mon_e.id), 32'(ovf4), 32'(mon_e.o4));
         end
      end
   end

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      pulse_in = 1'b0;

      // Reset and idle with the input toggling.
      run(4, 5);
      chk("rst_outs8", 32'({freq8, ovf8, v8, busy8}), 32'd0);
      chk("rst_outs4", 32'({freq4, ovf4, v4, busy4}), 32'd0);
      rst = 1'b0;
      run(4, 40);
      chk("idle_outs8", 32'({freq8, ovf8, v8, busy8}), 32'd0);
      chk("idle_outs4", 32'({freq4, ovf4, v4, busy4}), 32'd0);
      #3 rst = 1'b1;
      #1 chk("idle_rst_busy", 32'({busy8, busy4}), 32'd0);
      run(4, 8);
      rst = 1'b0;
      run(4, 20);

      // Steady rate: period 10 gives 10 rises per 100-cycle window.
      run(10, 20);
      enable = 1'b1;
      c0 = cyc;
      for (int w = 0; w < 3; w++) begin
         expect_win(c0 + 104 + 100 * w, 10, 1'b0, 10, 1'b0);
      end
      run(10, 10);
      chk("steady_busy", 32'({busy8, busy4}), 32'd3);
      run(10, 324);

      // Reset in the middle of window 3: immediate clear, no result.
      chk("pre_rst_freq8", 32'(freq8), 32'd10);
      #3 rst = 1'b1;
      #1 chk("midwin_rst_outs8", 32'({freq8, ovf8, v8, busy8}), 32'd0);
      chk("midwin_rst_outs4", 32'({freq4, ovf4, v4, busy4}), 32'd0);
      enable = 1'b0;
      run(10, 5);
      rst = 1'b0;
      run(10, 120);
      chk("post_rst_busy", 32'({busy8, busy4}), 32'd0);

      // Boundary edges: a rise on the closing cycle of window 0 and one on
      // the first cycle of window 2; window 1 sees none.
      pulse_in = 1'b0;
      enable   = 1'b1;
      c0 = cyc;
      expect_win(c0 + 104, 1, 1'b0, 1, 1'b0);
      expect_win(c0 + 204, 0, 1'b0, 0, 1'b0);
      expect_win(c0 + 304, 1, 1'b0, 1, 1'b0);
      for (int i = 0; i < 330; i++) begin
         pulse_in = ((i >= 101) && (i < 106)) || ((i >= 202) && (i < 207));
         if (i == 320) enable = 1'b0;
         step();
      end
      pulse_in = 1'b0;
      for (int i = 0; i < 5; i++) step();

      // Saturation: 50 rises in window 0, then period 10 from window 1 on.
      // Window 3 is aborted at gate count 60.
      enable = 1'b1;
      c0 = cyc;
      expect_win(c0 + 104, 50, 1'b0, 15, 1'b1);
      expect_win(c0 + 204, 10, 1'b0, 10, 1'b0);
      expect_win(c0 + 304, 10, 1'b0, 10, 1'b0);
      for (int i = 0; i < 365; i++) begin
         if (i < 102) pulse_in = ((i % 2) == 0);
         else         pulse_in = (((i - 102) % 10) < 5);
         if (i == 364) enable = 1'b0;
         step();
         if (i == 363) chk("busy_before_abort", 32'({busy8, busy4}), 32'd3);
      end
      chk("abort_busy", 32'({busy8, busy4}), 32'd0);
      chk("abort_hold8", 32'({freq8, ovf8}), 32'({8'd10, 1'b0}));
      chk("abort_hold4", 32'({freq4, ovf4}), 32'({4'd10, 1'b0}));

      // Re-enable on the first IDLE cycle; period 20 gives 5 rises. Enable
      // drops on the closing cycle: the window still publishes, then IDLE.
      enable = 1'b1;
      c0 = cyc;
      expect_win(c0 + 104, 5, 1'b0, 5, 1'b0);
      for (int i = 0; i < 106; i++) begin
         pulse_in = ((i % 20) < 10);
         if (i == 103) enable = 1'b0;
         step();
         if (i == 104) chk("close_disable_idle", 32'({busy8, busy4}), 32'd0);
      end
      run(20, 150);
      chk("final_hold8", 32'({freq8, ovf8, busy8}), 32'({8'd5, 1'b0, 1'b0}));
      chk("final_hold4", 32'({freq4, ovf4, busy4}), 32'({4'd5, 1'b0, 1'b0}));

      step();
      chk("missing_valids", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pulse_freq_meter.md
Name: pulse_freq_meter

Overview:
- Measures the rate of a slow external pulse train, such as a float-switch or flow-sensor pulse, against the 1 kHz system clock.
- Counts rising edges inside a fixed gate window of GATE_CYCLES clocks and publishes the count once per window.
- Acts as the measuring counterpart of the clock-divider blocks: dividers generate slow rates from clk, this block recovers a slow rate back into a number.
- Output feeds the level-control logic and the display path.

Parameters:
- GATE_CYCLES, 1000, gate window length in clk cycles (1 s at 1 kHz); legal range 2..2^24-1.
- CNT_W, 16, width of the edge counter and of freq_out.
- SYNC_STAGES, 2, synchronizer flip-flop depth for pulse_in; legal range 2..4.

Ports:
- clk  input  1  system clock (1 kHz in the product).
- rst  input  1  asynchronous, active-high reset.
- pulse_in  input  1  asynchronous external pulse signal.
- enable  input  1  level; high = measure continuously.
- freq_out  output  CNT_W  rising-edge count of the last completed window.
- freq_valid  output  1  one-cycle strobe when freq_out updates.
- overflow  output  1  last completed window saturated the counter.
- busy  output  1  high in SETTLE or MEASURE.

Behaviour:
- Reset (async, active-high): every register is cleared. freq_out=0, freq_valid=0, overflow=0, busy=0, state=IDLE.
- Input path: pulse_in passes through a SYNC_STAGES flip-flop synchronizer, then a registered edge detector. rise = sync & ~sync_d. Edge-to-rise latency = SYNC_STAGES+1 clocks.
- State machine:
  - IDLE: busy=0; gate_cnt=0, edge_cnt=0. When enable=1, go to SETTLE.
  - SETTLE: lasts SYNC_STAGES+1 cycles. The synchronizer and sync_d keep updating; rise is ignored so a stale level is never counted. Then go to MEASURE with gate_cnt=0, edge_cnt=0.
  - MEASURE:
    - gate_cnt increments every cycle.
    - On rise, edge_cnt increments, saturating at 2^CNT_W-1; saturation sets an internal ovf_pend flag.
    - When gate_cnt==GATE_CYCLES-1 (window close):
      - freq_out <= edge_cnt + rise, saturating.
      - overflow <= ovf_pend, or the saturation caused by that final add.
      - freq_valid=1 for exactly one cycle.
      - gate_cnt, edge_cnt and ovf_pend restart from 0 in the same cycle (back-to-back windows, no dead cycle).
      - A rise on the closing cycle belongs to the closing window. A rise on the following cycle belongs to the new window.
- enable deasserted in SETTLE or MEASURE: abort at the next edge and go to IDLE. No freq_valid is issued for the partial window. freq_out and overflow hold their last published values.
- enable deasserted on the exact closing cycle: that window still publishes (freq_valid=1), then the block goes to IDLE.
- enable re-asserted on the cycle after IDLE is entered: full SETTLE again; no state carries over.
- Reset mid-window: immediate clear; no valid is issued.
- gate_cnt width = clog2(GATE_CYCLES). edge_cnt never wraps.
- freq_valid is registered and never high in IDLE or SETTLE.

Decomposition:
- Shared package pkg_flood_common holds:
  - the state enum (IDLE, SETTLE, MEASURE);
  - constant SYS_CLK_HZ=1000;
  - a clog2-based width helper used by all divider and counter blocks.
- One sub-module, sync_edge_det: parameterized synchronizer plus rising-edge detector, reusable for the sensor inputs. Everything else stays in pulse_freq_meter.

Test Plan (GATE_CYCLES=100, CNT_W=8, SYNC_STAGES=2 unless noted):
- Reset/idle:
  - Stimulus: assert rst mid-stream with pulses toggling, enable=0.
  - Required response: all outputs 0; no freq_valid ever; busy=0.
- Steady rate:
  - Stimulus: enable=1, pulse_in period 10 clk (50% duty).
  - Required response: first freq_valid exactly 3+100 cycles after enable rises. Every window after that gives freq_out=10, with freq_valid spaced exactly 100 cycles apart.
- Boundary edge:
  - Stimulus: a single rise aligned to the window-close cycle.
  - Required response: counted in the closing window (freq_out=1), and the next window reports 0.
- Saturation:
  - Stimulus: CNT_W=4, pulse period 2 clk (50 rises per window).
  - Required response: freq_out=15, overflow=1.
  - Follow-on: next window at period 10 gives freq_out=10, overflow=0.
- Abort:
  - Stimulus: drop enable at gate_cnt=60.
  - Required response: no freq_valid; freq_out holds its prior value; busy=0 next cycle.
  - Follow-on: re-enable and run a full window; result is correct with no leftover counts.
- Close-cycle disable:
  - Stimulus: drop enable on the closing cycle.
  - Required response: freq_valid=1 with the correct count, then IDLE.
